// File: rtl/layer_sched_pkg.sv
// Shared types for the layer sequencer: descriptor layout, FSM states, descriptor word indices.
package tiny_dnn_ctrl_pkg;

   localparam int W_SHAPE_I = 0;
   localparam int W_SHAPE_O = 1;
   localparam int W_BATCH   = 2;
   localparam int W_FLAGS   = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_WLOAD,
      S_BLOAD,
      S_RUN,
      S_GAP_W,
      S_GAP_B,
      S_GAP_R,
      S_DONE
   } sched_state_e;

   typedef struct packed {
      logic [3:0]  id;
      logic [9:0]  is;
      logic [4:0]  ih;
      logic [4:0]  iw;
      logic [2:0]  kh;
      logic [2:0]  kw;
      logic [3:0]  od;
      logic [9:0]  os;
      logic [4:0]  oh;
      logic [4:0]  ow;
      logic [7:0]  fs;
      logic [11:0] ss;
      logic [11:0] ds;
      logic [7:0]  nsamp;
      logic        bload_en;
      logic        wload_en;
   } layer_desc_t;

   // A zero sample count would never finish the run phase, so it means one sample.
   function automatic logic [7:0] samp_target(input logic [7:0] nsamp);
      return (nsamp == 8'd0) ? 8'd1 : nsamp;
   endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Descriptor write bus, observed input stream and phase controls between host side and layer_sched.
interface layer_sched_if;
   logic        cfg_we;
   logic [5:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        src_valid;
   logic        src_ready;
   logic        src_last;
   logic        s_fin;
   logic        run;
   logic        wwrite;
   logic        bwrite;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, src_valid, src_ready, src_last, s_fin,
      input  run, wwrite, bwrite
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, src_valid, src_ready, src_last, s_fin,
      output run, wwrite, bwrite
   );
endinterface

// File: rtl/layer_sched_desc_ram.sv
// Descriptor table: DEPTH layers x 4 words x 32 bits, word-granular write, registered whole-row read.
module layer_desc_ram #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [5:0]    wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_layer,
   output logic [127:0]  rd_row
);

   logic [31:0] mem [DEPTH][4];

   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr[5:2]} < 5'(DEPTH))) begin
         mem[wr_addr[2 +: AW]][wr_addr[1:0]] <= wr_data;
      end
      rd_row <= {mem[rd_layer][3], mem[rd_layer][2], mem[rd_layer][1], mem[rd_layer][0]};
   end

endmodule

// File: rtl/layer_sched.sv
// Multi-layer sequencer: walks the descriptor table, drives weight/bias/run phases per layer.
// Optional PERF_CNT_EN adds saturating per-phase cycle counters cyc_wload/cyc_bload/cyc_run.
module layer_sched
   import tiny_dnn_ctrl_pkg::*;
#(
   parameter int MAX_LAYERS = 16
`ifdef PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic         clk,
   input  logic         rst,
   layer_sched_if.slave bus,
   input  logic [4:0]   nlayers,
   input  logic         start,
   input  logic         abort,
   output logic [3:0]   id,
   output logic [9:0]   is,
   output logic [4:0]   ih,
   output logic [4:0]   iw,
   output logic [3:0]   od,
   output logic [9:0]   os,
   output logic [4:0]   oh,
   output logic [4:0]   ow,
   output logic [7:0]   fs,
   output logic [2:0]   kh,
   output logic [2:0]   kw,
   output logic [11:0]  ss,
   output logic [11:0]  ds,
   output logic [3:0]   layer_idx,
   output logic         busy,
   output logic         done
`ifdef PERF_CNT_EN
   , output logic [CNT_W-1:0] cyc_wload
   , output logic [CNT_W-1:0] cyc_bload
   , output logic [CNT_W-1:0] cyc_run
`endif
);

   localparam int LAW = $clog2(MAX_LAYERS);

   sched_state_e state, state_nx;
   layer_desc_t  cur, fetch_desc;
   logic [127:0] rd_row;
   logic [31:0]  wrd_i, wrd_o, wrd_b, wrd_f;
   logic [3:0]   rd_idx;
   logic [4:0]   nlayers_r;
   logic [7:0]   samp_cnt;
   logic         phase_end, last_samp, last_layer;
   logic         ctl_run, ctl_wwrite, ctl_bwrite;
   logic         unused_pad;

   // The row for the next FETCH is read a cycle early: layer 0 while idle, layer_idx+1 otherwise.
   assign rd_idx = (state == S_IDLE) ? 4'd0 : layer_idx + 4'd1;

   layer_desc_ram #(.DEPTH(MAX_LAYERS)) u_ram (
      .clk      (clk),
      .wr_en    (bus.cfg_we & ~busy),
      .wr_addr  (bus.cfg_addr),
      .wr_data  (bus.cfg_wdata),
      .rd_layer (rd_idx[LAW-1:0]),
      .rd_row   (rd_row)
   );

   assign wrd_i = rd_row[W_SHAPE_I*32 +: 32];
   assign wrd_o = rd_row[W_SHAPE_O*32 +: 32];
   assign wrd_b = rd_row[W_BATCH*32 +: 32];
   assign wrd_f = rd_row[W_FLAGS*32 +: 32];

   always_comb begin
      fetch_desc          = '0;
      fetch_desc.id       = wrd_i[29:26];
      fetch_desc.is       = wrd_i[25:16];
      fetch_desc.ih       = wrd_i[15:11];
      fetch_desc.iw       = wrd_i[10:6];
      fetch_desc.kh       = wrd_i[5:3];
      fetch_desc.kw       = wrd_i[2:0];
      fetch_desc.od       = wrd_o[31:28];
      fetch_desc.os       = wrd_o[27:18];
      fetch_desc.oh       = wrd_o[17:13];
      fetch_desc.ow       = wrd_o[12:8];
      fetch_desc.fs       = wrd_o[7:0];
      fetch_desc.ss       = wrd_b[31:20];
      fetch_desc.ds       = wrd_b[19:8];
      fetch_desc.nsamp    = wrd_b[7:0];
      fetch_desc.bload_en = wrd_f[1];
      fetch_desc.wload_en = wrd_f[0];
   end

   assign unused_pad = ^{wrd_i[31:30], wrd_f[31:2], cur.wload_en};

   assign phase_end  = bus.src_valid & bus.src_ready & bus.src_last;
   assign last_samp  = ({1'b0, samp_cnt} + 9'd1) == {1'b0, samp_target(cur.nsamp)};
   assign last_layer = ({1'b0, layer_idx} + 5'd1) >= nlayers_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      ctl_run    = 1'b0;
      ctl_wwrite = 1'b0;
      ctl_bwrite = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (nlayers_r == 5'd0)       state_nx = S_DONE;
            else if (fetch_desc.wload_en) state_nx = S_WLOAD;
            else if (fetch_desc.bload_en) state_nx = S_BLOAD;
            else                          state_nx = S_RUN;
         end
         S_WLOAD: begin
            ctl_wwrite = 1'b1;
            if (phase_end) state_nx = S_GAP_W;
         end
         S_GAP_W: state_nx = cur.bload_en ? S_BLOAD : S_RUN;
         S_BLOAD: begin
            ctl_bwrite = 1'b1;
            if (phase_end) state_nx = S_GAP_B;
         end
         S_GAP_B: state_nx = S_RUN;
         S_RUN: begin
            ctl_run = 1'b1;
            if (bus.s_fin && last_samp) state_nx = S_GAP_R;
         end
         S_GAP_R: state_nx = last_layer ? S_DONE : S_FETCH;
         S_DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
      if (abort) state_nx = S_IDLE;
   end

   assign bus.run    = ctl_run;
   assign bus.wwrite = ctl_wwrite;
   assign bus.bwrite = ctl_bwrite;

   // Sequence bookkeeping; shape outputs only change on a real FETCH so they survive idle and abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer_idx <= 4'd0;
         samp_cnt  <= 8'd0;
         nlayers_r <= 5'd0;
         cur       <= '0;
      end else if (abort) begin
         layer_idx <= 4'd0;
         samp_cnt  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               nlayers_r <= nlayers;
               layer_idx <= 4'd0;
               samp_cnt  <= 8'd0;
            end
            S_FETCH: if (nlayers_r != 5'd0) cur <= fetch_desc;
            S_RUN:   if (bus.s_fin) samp_cnt <= last_samp ? 8'd0 : samp_cnt + 8'd1;
            S_GAP_R: if (!last_layer) layer_idx <= layer_idx + 4'd1;
            default: ;
         endcase
      end
   end

   assign id = cur.id;
   assign is = cur.is;
   assign ih = cur.ih;
   assign iw = cur.iw;
   assign od = cur.od;
   assign os = cur.os;
   assign oh = cur.oh;
   assign ow = cur.ow;
   assign fs = cur.fs;
   assign kh = cur.kh;
   assign kw = cur.kw;
   assign ss = cur.ss;
   assign ds = cur.ds;

`ifdef PERF_CNT_EN
   // Counters restart on an accepted start and freeze outside the phases they measure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_wload <= '0;
         cyc_bload <= '0;
         cyc_run   <= '0;
      end else if (state == S_IDLE && start && !abort) begin
         cyc_wload <= '0;
         cyc_bload <= '0;
         cyc_run   <= '0;
      end else begin
         if (state == S_WLOAD && cyc_wload != '1) cyc_wload <= cyc_wload + 1'b1;
         if (state == S_BLOAD && cyc_bload != '1) cyc_bload <= cyc_bload + 1'b1;
         if (state == S_RUN   && cyc_run   != '1) cyc_run   <= cyc_run + 1'b1;
      end
   end
`endif

endmodule
